tile_puzzle_gpu: RTL
====================

Name: tile_puzzle_gpu

Overview:
Parametrised successor of the fixed 16x16 puzzle GPU. Takes one-shot user instructions to move a flashing cursor or rotate a grid row/column through the tile RAM, and renders the tile image into a configurable VGA window. New in this generation:
- grid size, colour depth and window geometry are parameters;
- RAM rotates use a req/ack handshake;
- the pixel path is pipelined;
- an optional auto-shuffle instruction.

Parameters:
GRID_BITS, 4, log2 of grid cells per side; cursor and RAM coordinates are GRID_BITS wide.
COLOR_W, 3, pixel colour width.
COORD_W, 11, width of each display coordinate.
WIN_X0, 231, first visible column of the image window.
WIN_Y0, 36, first visible row of the image window.
WIN_SIZE, 481, window side length in pixels (inclusive span WIN_X0..WIN_X0+WIN_SIZE-1).
FLASH_BITS, 25, cursor flash counter width; flash toggles on counter wrap.
SHUFFLE_MOVES, 64, rotates issued per shuffle instruction.

Ports:
sysclk  in  1  system clock, all logic rising-edge.
reset  in  1  synchronous active-high reset.
instruction  in  4  0 none, 1 up, 2 right, 3 left, 4 down, 5 ram reset, 6 shuffle.
scramble  in  1  1: directions rotate grid lines; 0: directions move cursor.
display_addr  in  2*COORD_W  {x, y} of the pixel being scanned.
mapper_display_addr  out  2*COORD_W  registered display_addr fed to the coordinate mapper.
mapper_pixel_x  in  GRID_BITS  mapper's cell x for mapper_display_addr (combinational, same cycle).
mapper_pixel_y  in  GRID_BITS  mapper's cell y.
offset_x  in  GRID_BITS  image scroll offset, x.
offset_y  in  GRID_BITS  image scroll offset, y.
pixel_addr  out  2*GRID_BITS  tile RAM read address {y, x}.
pixel_data  in  COLOR_W  tile RAM read data (asynchronous read of pixel_addr).
display_data  out  COLOR_W  colour to the VGA output.
ram_write  out  1  rotate request, held until ram_ack.
ram_ack  in  1  RAM has accepted the rotate.
ram_write_pos  out  GRID_BITS  row/column index being rotated.
ram_write_horizontal  out  1  1 = rotate a row, 0 = rotate a column.
ram_write_increase  out  1  rotation direction.
ram_reset  out  1  one-cycle pulse that restores the RAM image.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; cursor (0,0); flash counter 0; flash phase 0; LFSR seed 1; FSM in IDLE.
- Command FSM states: IDLE, REQ, SHUF, WAIT_REL.
- IDLE:
  - instruction 1-4 with scramble=0: move cursor in 1 cycle, wrapping both ways (0 up -> 2^GRID_BITS-1, max right -> 0); go to WAIT_REL.
  - instruction 1-4 with scramble=1: load rotate fields and assert ram_write; go to REQ.
    - 1 up: column cursor_x, horizontal=0, increase=1.
    - 2 right: row cursor_y, horizontal=1, increase=0.
    - 3 left: row cursor_y, horizontal=1, increase=1.
    - 4 down: column cursor_x, horizontal=0, increase=0.
  - instruction 5: pulse ram_reset for exactly 1 cycle; go to WAIT_REL.
  - instruction 6: go to SHUF (only with the optional feature).
- REQ: hold ram_write and all fields stable until a cycle with ram_ack=1. In that cycle deassert ram_write and go to WAIT_REL, or back to SHUF if a shuffle is in progress. ram_ack is ignored outside REQ.
- WAIT_REL: go to IDLE only when instruction==0. One action per key press.
- A new instruction received while busy is ignored.
- Reset mid-handshake: ram_write drops on the next edge; any pending rotate is discarded.
- Pixel pipeline:
  - S1: register display_addr into mapper_display_addr; set window flag = x in [WIN_X0, WIN_X0+WIN_SIZE-1] and y in [WIN_Y0, WIN_Y0+WIN_SIZE-1].
  - S2: register pixel_addr = {mapper_pixel_y+offset_y, mapper_pixel_x+offset_x}, each sum modulo 2^GRID_BITS. Register cursor hit = flash phase & (mapper_pixel_x==cursor_x) & (mapper_pixel_y==cursor_y). Delay the window flag.
  - S3: display_data = 0 outside the window; otherwise hit ? ~pixel_data : pixel_data.
  - Fixed latency: 3 cycles from display_addr to display_data.
- The flash counter runs freely, including during busy.

Optional Feature:
- Macro: TILE_PUZZLE_GPU_AUTOSHUFFLE_EN.
- When defined, instruction 6 enters SHUF and runs SHUFFLE_MOVES rotates.
  - Each rotate takes pos, horizontal and increase from a 16-bit Galois LFSR (taps 16,14,13,11) that advances every cycle.
  - Each rotate goes through REQ; busy stays high throughout.
  - After the last ack the FSM goes to WAIT_REL.
  - A move count of 0 is never possible.
- When undefined, instruction 6 behaves as none: no state change, busy stays 0. No LFSR logic is synthesised.

Decomposition:
- Package tile_gpu_pkg holds:
  - instruction opcode constants (INSTR_NONE through INSTR_SHUFFLE);
  - the FSM state enum;
  - the rotate request struct {pos, horizontal, increase}.
- One sub-module: tile_gpu_pixel_pipe, containing the S1-S3 pipeline, window compare and cursor hit.

Test Plan:
- Cursor wrap: GRID_BITS=4, cursor (0,0), scramble=0, instruction 1 then 0, then 3 then 0 -> cursor (15,15); busy high 1 cycle per press.
- Held key: instruction 2 held 100 cycles -> cursor_x advances exactly once; IDLE only after instruction=0.
- Rotate handshake: scramble=1, cursor (5,9), instruction 2, ram_ack delayed 7 cycles -> ram_write high 7 cycles with pos=9, horizontal=1, increase=0; drops the cycle after ack.
- Pixel window: display_addr x=230,231,711,712 with y=100 -> display_data 0, data, data, 0 after 3 cycles; at the cursor cell in flash phase 1 with pixel_data 3'b101 -> 3'b010.
- Offset wrap: mapper_pixel_x=14, offset_x=3 -> pixel_addr x field 1.
- Shuffle (macro defined, SHUFFLE_MOVES=4, ram_ack tied 1): instruction 6 -> exactly 4 ram_write pulses, then WAIT_REL. Macro undefined -> no pulses, busy stays 0.

Source files
------------

// File: rtl/tile_gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tile_gpu_pkg
// Description : Shared opcodes, command FSM state encoding, rotate request
//               type and LFSR step function for the tile puzzle GPU.
// Revision    : 1.0 - initial parametrised generation
// ============================================================================
package tile_gpu_pkg;

  // User instruction opcodes
  localparam logic [3:0] INSTR_NONE      = 4'd0;
  localparam logic [3:0] INSTR_UP        = 4'd1;
  localparam logic [3:0] INSTR_RIGHT     = 4'd2;
  localparam logic [3:0] INSTR_LEFT      = 4'd3;
  localparam logic [3:0] INSTR_DOWN      = 4'd4;
  localparam logic [3:0] INSTR_RAM_RESET = 4'd5;
  localparam logic [3:0] INSTR_SHUFFLE   = 4'd6;

  // Widest row/column index a rotate request can carry
  localparam int ROT_POS_W = 16;

  // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Command FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_SHUF     = 2'd2,
    ST_WAIT_REL = 2'd3
  } cmd_state_e;

  // Rotate request presented to the tile RAM
  typedef struct packed {
    logic [ROT_POS_W-1:0] pos;
    logic                 horizontal;
    logic                 increase;
  } rot_req_t;

  // One step of the 16-bit Galois LFSR
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tile_gpu_pixel_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tile_gpu_pixel_pipe
// Description : Three-stage pixel path. S1 registers the scan address and
//               window flag, S2 forms the scrolled tile RAM address and the
//               cursor hit, S3 produces the final (optionally inverted) colour.
// Revision    : 1.0 - initial parametrised generation
// ============================================================================
module tile_gpu_pixel_pipe #(
  parameter int GRID_BITS = 4,
  parameter int COLOR_W   = 3,
  parameter int COORD_W   = 11,
  parameter int WIN_X0    = 231,
  parameter int WIN_Y0    = 36,
  parameter int WIN_SIZE  = 481
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic [2*COORD_W-1:0]   display_addr,
  output logic [2*COORD_W-1:0]   mapper_display_addr,
  input  logic [GRID_BITS-1:0]   mapper_pixel_x,
  input  logic [GRID_BITS-1:0]   mapper_pixel_y,
  input  logic [GRID_BITS-1:0]   offset_x,
  input  logic [GRID_BITS-1:0]   offset_y,
  input  logic [GRID_BITS-1:0]   cursor_x,
  input  logic [GRID_BITS-1:0]   cursor_y,
  input  logic                   flash,
  output logic [2*GRID_BITS-1:0] pixel_addr,
  input  logic [COLOR_W-1:0]     pixel_data,
  output logic [COLOR_W-1:0]     display_data
);

  localparam logic [COORD_W-1:0] c_x_lo = COORD_W'(WIN_X0);
  localparam logic [COORD_W-1:0] c_x_hi = COORD_W'(WIN_X0 + WIN_SIZE - 1);
  localparam logic [COORD_W-1:0] c_y_lo = COORD_W'(WIN_Y0);
  localparam logic [COORD_W-1:0] c_y_hi = COORD_W'(WIN_Y0 + WIN_SIZE - 1);

  logic [COORD_W-1:0]     scan_x;
  logic [COORD_W-1:0]     scan_y;
  logic [2*COORD_W-1:0]   addr_q,  addr_d;
  logic                   win1_q,  win1_d;
  logic [2*GRID_BITS-1:0] paddr_q, paddr_d;
  logic                   hit_q,   hit_d;
  logic                   win2_q,  win2_d;
  logic [COLOR_W-1:0]     disp_q,  disp_d;

  assign scan_x = display_addr[2*COORD_W-1:COORD_W];
  assign scan_y = display_addr[COORD_W-1:0];

  // Next values of all three pipeline stages
  always_comb begin
    addr_d  = display_addr;
    win1_d  = (scan_x >= c_x_lo) && (scan_x <= c_x_hi) &&
              (scan_y >= c_y_lo) && (scan_y <= c_y_hi);
    // Sums keep GRID_BITS width so scrolling wraps around the grid
    paddr_d = {mapper_pixel_y + offset_y, mapper_pixel_x + offset_x};
    hit_d   = flash && (mapper_pixel_x == cursor_x) && (mapper_pixel_y == cursor_y);
    win2_d  = win1_q;
    disp_d  = win2_q ? (hit_q ? ~pixel_data : pixel_data) : '0;
  end

  // Pipeline registers
  always_ff @(posedge sysclk) begin
    if (reset) begin
      addr_q  <= '0;
      win1_q  <= 1'b0;
      paddr_q <= '0;
      hit_q   <= 1'b0;
      win2_q  <= 1'b0;
      disp_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      win1_q  <= win1_d;
      paddr_q <= paddr_d;
      hit_q   <= hit_d;
      win2_q  <= win2_d;
      disp_q  <= disp_d;
    end
  end

  assign mapper_display_addr = addr_q;
  assign pixel_addr          = paddr_q;
  assign display_data        = disp_q;

endmodule
`default_nettype wire

// File: rtl/tile_puzzle_gpu.sv
`default_nettype none
// ============================================================================
// Module      : tile_puzzle_gpu
// Description : Puzzle GPU top. Command FSM for cursor moves, row/column
//               rotates (req/ack to the tile RAM) and RAM reset, free-running
//               cursor flash, and the pipelined pixel path.
//               Optional auto-shuffle: TILE_PUZZLE_GPU_AUTOSHUFFLE_EN.
// Revision    : 1.0 - initial parametrised generation
// ============================================================================
module tile_puzzle_gpu
  import tile_gpu_pkg::*;
#(
  parameter int GRID_BITS     = 4,
  parameter int COLOR_W       = 3,
  parameter int COORD_W       = 11,
  parameter int WIN_X0        = 231,
  parameter int WIN_Y0        = 36,
  parameter int WIN_SIZE      = 481,
  parameter int FLASH_BITS    = 25,
  parameter int SHUFFLE_MOVES = 64
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic [3:0]             instruction,
  input  logic                   scramble,
  input  logic [2*COORD_W-1:0]   display_addr,
  output logic [2*COORD_W-1:0]   mapper_display_addr,
  input  logic [GRID_BITS-1:0]   mapper_pixel_x,
  input  logic [GRID_BITS-1:0]   mapper_pixel_y,
  input  logic [GRID_BITS-1:0]   offset_x,
  input  logic [GRID_BITS-1:0]   offset_y,
  output logic [2*GRID_BITS-1:0] pixel_addr,
  input  logic [COLOR_W-1:0]     pixel_data,
  output logic [COLOR_W-1:0]     display_data,
  output logic                   ram_write,
  input  logic                   ram_ack,
  output logic [GRID_BITS-1:0]   ram_write_pos,
  output logic                   ram_write_horizontal,
  output logic                   ram_write_increase,
  output logic                   ram_reset,
  output logic                   busy
);

  localparam logic [GRID_BITS-1:0] c_cell_one = GRID_BITS'(1);
  localparam int                   c_pad_w    = ROT_POS_W - GRID_BITS;

  cmd_state_e             state_q, state_d;
  logic [GRID_BITS-1:0]   cursor_x_q, cursor_x_d;
  logic [GRID_BITS-1:0]   cursor_y_q, cursor_y_d;
  rot_req_t               rot_q, rot_d;
  logic                   ram_reset_q, ram_reset_d;
  logic [FLASH_BITS-1:0]  flash_cnt_q, flash_cnt_d;
  logic                   flash_q, flash_d;
  logic                   unused_pos_hi;

`ifdef TILE_PUZZLE_GPU_AUTOSHUFFLE_EN
  // A zero-length shuffle is clamped to one rotate
  localparam int SHUF_N = (SHUFFLE_MOVES < 1) ? 1 : SHUFFLE_MOVES;
  localparam int SHUF_W = $clog2(SHUF_N + 1);
  logic [15:0]       lfsr_q, lfsr_d;
  logic [SHUF_W-1:0] shuf_cnt_q, shuf_cnt_d;
`else
  localparam int unused_shuffle_moves = SHUFFLE_MOVES;
`endif

  // State register and all datapath flops
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cursor_x_q  <= '0;
      cursor_y_q  <= '0;
      rot_q       <= '0;
      ram_reset_q <= 1'b0;
      flash_cnt_q <= '0;
      flash_q     <= 1'b0;
`ifdef TILE_PUZZLE_GPU_AUTOSHUFFLE_EN
      lfsr_q      <= 16'h0001;
      shuf_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cursor_x_q  <= cursor_x_d;
      cursor_y_q  <= cursor_y_d;
      rot_q       <= rot_d;
      ram_reset_q <= ram_reset_d;
      flash_cnt_q <= flash_cnt_d;
      flash_q     <= flash_d;
`ifdef TILE_PUZZLE_GPU_AUTOSHUFFLE_EN
      lfsr_q      <= lfsr_d;
      shuf_cnt_q  <= shuf_cnt_d;
`endif
    end
  end

  // Next-state and next-datapath logic of the command FSM
  always_comb begin
    state_d     = state_q;
    cursor_x_d  = cursor_x_q;
    cursor_y_d  = cursor_y_q;
    rot_d       = rot_q;
    ram_reset_d = 1'b0;
    // Flash runs regardless of FSM activity; phase flips on counter wrap
    flash_cnt_d = flash_cnt_q + FLASH_BITS'(1);
    flash_d     = (flash_cnt_q == '1) ? ~flash_q : flash_q;
`ifdef TILE_PUZZLE_GPU_AUTOSHUFFLE_EN
    lfsr_d      = lfsr_next(lfsr_q);
    shuf_cnt_d  = shuf_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        case (instruction)
          INSTR_UP, INSTR_RIGHT, INSTR_LEFT, INSTR_DOWN: begin
            if (scramble) begin
              // Up/down rotate the cursor column, left/right the cursor row
              if (instruction == INSTR_UP || instruction == INSTR_DOWN) begin
                rot_d.pos        = {{c_pad_w{1'b0}}, cursor_x_q};
                rot_d.horizontal = 1'b0;
                rot_d.increase   = (instruction == INSTR_UP);
              end else begin
                rot_d.pos        = {{c_pad_w{1'b0}}, cursor_y_q};
                rot_d.horizontal = 1'b1;
                rot_d.increase   = (instruction == INSTR_LEFT);
              end
              state_d = ST_REQ;
            end else begin
              case (instruction)
                INSTR_UP:    cursor_y_d = cursor_y_q - c_cell_one;
                INSTR_DOWN:  cursor_y_d = cursor_y_q + c_cell_one;
                INSTR_RIGHT: cursor_x_d = cursor_x_q + c_cell_one;
                default:     cursor_x_d = cursor_x_q - c_cell_one;
              endcase
              state_d = ST_WAIT_REL;
            end
          end
          INSTR_RAM_RESET: begin
            ram_reset_d = 1'b1;
            state_d     = ST_WAIT_REL;
          end
`ifdef TILE_PUZZLE_GPU_AUTOSHUFFLE_EN
          INSTR_SHUFFLE: begin
            shuf_cnt_d = SHUF_W'(SHUF_N);
            state_d    = ST_SHUF;
          end
`endif
          default: state_d = ST_IDLE;
        endcase
      end
      ST_REQ: begin
        if (ram_ack) begin
`ifdef TILE_PUZZLE_GPU_AUTOSHUFFLE_EN
          // Remaining shuffle moves send us back for another rotate
          state_d = (shuf_cnt_q != '0) ? ST_SHUF : ST_WAIT_REL;
`else
          state_d = ST_WAIT_REL;
`endif
        end
      end
      ST_SHUF: begin
`ifdef TILE_PUZZLE_GPU_AUTOSHUFFLE_EN
        rot_d.pos        = {{c_pad_w{1'b0}}, lfsr_q[GRID_BITS-1:0]};
        rot_d.horizontal = lfsr_q[GRID_BITS];
        rot_d.increase   = lfsr_q[GRID_BITS+1];
        shuf_cnt_d       = shuf_cnt_q - SHUF_W'(1);
        state_d          = ST_REQ;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_WAIT_REL: begin
        if (instruction == INSTR_NONE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    ram_write = (state_q == ST_REQ);
    busy      = (state_q != ST_IDLE);
  end

  assign ram_write_pos        = rot_q.pos[GRID_BITS-1:0];
  assign ram_write_horizontal = rot_q.horizontal;
  assign ram_write_increase   = rot_q.increase;
  assign ram_reset            = ram_reset_q;
  assign unused_pos_hi        = ^rot_q.pos[ROT_POS_W-1:GRID_BITS];

  tile_gpu_pixel_pipe #(
    .GRID_BITS (GRID_BITS),
    .COLOR_W   (COLOR_W),
    .COORD_W   (COORD_W),
    .WIN_X0    (WIN_X0),
    .WIN_Y0    (WIN_Y0),
    .WIN_SIZE  (WIN_SIZE)
  ) u_pixel_pipe (
    .sysclk              (sysclk),
    .reset               (reset),
    .display_addr        (display_addr),
    .mapper_display_addr (mapper_display_addr),
    .mapper_pixel_x      (mapper_pixel_x),
    .mapper_pixel_y      (mapper_pixel_y),
    .offset_x            (offset_x),
    .offset_y            (offset_y),
    .cursor_x            (cursor_x_q),
    .cursor_y            (cursor_y_q),
    .flash               (flash_q),
    .pixel_addr          (pixel_addr),
    .pixel_data          (pixel_data),
    .display_data        (display_data)
  );

endmodule
`default_nettype wire
